// File: rtl/instr_decode_stage.sv
// IF/ID boundary stage: accepts fetched {pc, instr} over valid/ready,
// runs the main opcode decoder on the incoming word and holds the decoded
// result in a 2-entry skid buffer (main + skid). All ID-side outputs come
// from the main entry, and if_ready is derived from state flops only.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 (push = if_valid & if_ready, pop = id_valid & id_ready). Producers
// hold their payload stable while valid=1 and ready=0; this stage keeps all
// id_* outputs stable while id_valid=1 and id_ready=0.
module instr_decode_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_instr,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic [2:0]      id_imm_src,
  output logic            id_reg_write,
  output logic            id_mem_write,
  output logic            id_alu_src,
  output logic [1:0]      id_result_src,
  output logic [1:0]      id_alu_op,
  output logic            id_branch,
  output logic            id_jump,
  output logic            id_illegal,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] imm_src;
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    ctrl_t           ctrl;
  } entry_t;

  localparam ctrl_t  CTRL_NONE = '0;
  localparam entry_t ENTRY_RST = '{pc: '0, instr: NOP_INSTR, ctrl: CTRL_NONE};

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  ctrl_t  dec_ctrl;
  entry_t new_entry;
  logic   push;
  logic   pop;

  // Main opcode decoder on the word currently offered by fetch.
  always_comb begin
    dec_ctrl = CTRL_NONE;
    case (if_instr[6:0])
      7'b0000011: begin // lw
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.result_src = 2'b01;
      end
      7'b0100011: begin // sw
        dec_ctrl.imm_src   = 3'b001;
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
      end
      7'b0110011: begin // R-type
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = 2'b10;
      end
      7'b0010011: begin // I-type ALU
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = 2'b10;
      end
      7'b1100011: begin // conditional branch
        dec_ctrl.imm_src = 3'b010;
        dec_ctrl.alu_op  = 2'b01;
        dec_ctrl.branch  = 1'b1;
      end
      7'b1101111: begin // jal
        dec_ctrl.imm_src    = 3'b011;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.result_src = 2'b10;
        dec_ctrl.jump       = 1'b1;
      end
      7'b1100111: begin // jalr
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.result_src = 2'b10;
        dec_ctrl.jump       = 1'b1;
      end
      7'b0110111, 7'b0010111: begin // lui, auipc
        dec_ctrl.imm_src   = 3'b100;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
      end
      default: begin
        // Unknown opcodes still travel down the pipe, flagged for the trap logic.
        dec_ctrl.illegal = 1'b1;
      end
    endcase
  end

  // Handshake terms; ready/valid depend on the state flop only.
  always_comb begin
    if_ready  = (state_q != ST_FULL);
    id_valid  = (state_q != ST_EMPTY);
    push      = if_valid & if_ready;
    pop       = id_valid & id_ready;
    new_entry = '{pc: if_pc, instr: if_instr, ctrl: dec_ctrl};
  end

  // Next-state and buffer update; flush overrides any push/pop this cycle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = ENTRY_RST;
      skid_d  = ENTRY_RST;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_d  = new_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_d = new_entry;
          end else if (push) begin
            skid_d  = new_entry;
            state_d = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Fetch is stalled here, so only a pop can move things.
          if (pop) begin
            main_d  = skid_q;
            skid_d  = ENTRY_RST;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = ENTRY_RST;
          skid_d  = ENTRY_RST;
        end
      endcase
    end
  end

  // State and both buffer entries; reset discards everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= ENTRY_RST;
      skid_q  <= ENTRY_RST;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // ID-side outputs are taken straight from the main entry flops.
  always_comb begin
    id_pc         = main_q.pc;
    id_instr      = main_q.instr;
    id_imm_src    = main_q.ctrl.imm_src;
    id_reg_write  = main_q.ctrl.reg_write;
    id_mem_write  = main_q.ctrl.mem_write;
    id_alu_src    = main_q.ctrl.alu_src;
    id_result_src = main_q.ctrl.result_src;
    id_alu_op     = main_q.ctrl.alu_op;
    id_branch     = main_q.ctrl.branch;
    id_jump       = main_q.ctrl.jump;
    id_illegal    = main_q.ctrl.illegal;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: a queue-based reference model of the
// 2-deep stage plus an opcode table, a per-cycle compare process, and
// directed vectors with hand-computed expectations.
module tb_instr_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [2:0]  id_imm_src;
  logic        id_reg_write;
  logic        id_mem_write;
  logic        id_alu_src;
  logic [1:0]  id_result_src;
  logic [1:0]  id_alu_op;
  logic        id_branch;
  logic        id_jump;
  logic        id_illegal;
  logic [1:0]  dbg_state;

  instr_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .id_imm_src(id_imm_src), .id_reg_write(id_reg_write), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_result_src(id_result_src), .id_alu_op(id_alu_op),
    .id_branch(id_branch), .id_jump(id_jump), .id_illegal(id_illegal),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // ctrl layout: {imm_src[2:0], reg_write, mem_write, alu_src, result_src[1:0], alu_op[1:0], branch, jump, illegal}
  logic [13:0] dec_tab [logic [6:0]];
  initial begin
    dec_tab[7'b0000011] = 14'b000_1_0_1_01_00_0_0_0;
    dec_tab[7'b0100011] = 14'b001_0_1_1_00_00_0_0_0;
    dec_tab[7'b0110011] = 14'b000_1_0_0_00_10_0_0_0;
    dec_tab[7'b0010011] = 14'b000_1_0_1_00_10_0_0_0;
    dec_tab[7'b1100011] = 14'b010_0_0_0_00_01_1_0_0;
    dec_tab[7'b1101111] = 14'b011_1_0_0_10_00_0_1_0;
    dec_tab[7'b1100111] = 14'b000_1_0_1_10_00_0_1_0;
    dec_tab[7'b0110111] = 14'b100_1_0_1_00_00_0_0_0;
    dec_tab[7'b0010111] = 14'b100_1_0_1_00_00_0_0_0;
  end

  function automatic logic [13:0] exp_ctrl(input logic [31:0] ins);
    if (dec_tab.exists(ins[6:0])) return dec_tab[ins[6:0]];
    return 14'b000_0_0_0_00_00_0_0_1;
  endfunction

  logic [63:0] exp_q[$];     // {pc, instr} in FIFO order; front is on the output
  logic [31:0] pop_log[$];   // pcs consumed downstream, in order
  logic        cleared;      // payload must show the reset/flush values while empty

  // Model advances on the same edge as the DUT, using only bench-driven inputs.
  always @(posedge clk) begin
    if (rst || flush) begin
      if (flush && !rst && exp_q.size() > 0 && id_ready) pop_log.push_back(exp_q[0][63:32]);
      exp_q.delete();
      cleared = 1'b1;
    end else begin
      logic do_pop, do_push;
      do_pop  = (exp_q.size() > 0) && id_ready;
      do_push = if_valid && (exp_q.size() < 2);
      if (do_pop) begin
        pop_log.push_back(exp_q[0][63:32]);
        void'(exp_q.pop_front());
      end
      if (do_push) begin
        exp_q.push_back({if_pc, if_instr});
        cleared = 1'b0;
      end
    end
  end

  // Compare DUT outputs against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [13:0] act_ctrl;
      act_ctrl = {id_imm_src, id_reg_write, id_mem_write, id_alu_src,
                  id_result_src, id_alu_op, id_branch, id_jump, id_illegal};
      chk("m_id_valid", 32'(id_valid), 32'(exp_q.size() > 0));
      chk("m_if_ready", 32'(if_ready), 32'(exp_q.size() < 2));
      if (exp_q.size() > 0) begin
        chk("m_id_pc", id_pc, exp_q[0][63:32]);
        chk("m_id_instr", id_instr, exp_q[0][31:0]);
        chk("m_ctrl", 32'(act_ctrl), 32'(exp_ctrl(exp_q[0][31:0])));
      end else if (cleared) begin
        chk("m_rst_pc", id_pc, 32'h0);
        chk("m_rst_instr", id_instr, 32'h00000013);
        chk("m_rst_ctrl", 32'(act_ctrl), 32'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 2 time units after a rising edge.
  task automatic send(input logic [31:0] pc, input logic [31:0] ins);
    logic acc;
    acc = 1'b0;
    if_pc = pc;
    if_instr = ins;
    if_valid = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = if_ready;
      @(posedge clk);
      #2;
    end
    if_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic to_neg;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    if_pc = '0; if_instr = '0;
    cleared = 1'b1;
    cycles(2);
    chk_en = 1'b1;
    rst = 1'b0;

    // 1: reset state
    to_neg();
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_if_ready", 32'(if_ready), 32'h1);
    chk("rst_id_instr", id_instr, 32'h00000013);
    chk("rst_ctrl", 32'({id_reg_write, id_mem_write, id_branch, id_jump, id_illegal}), 32'h0);
    cycles(1);

    // 2: lw with id_ready=1
    id_ready = 1'b1;
    send(32'h100, 32'h00412083);
    to_neg();
    chk("lw_valid", 32'(id_valid), 32'h1);
    chk("lw_pc", id_pc, 32'h100);
    chk("lw_imm_src", 32'(id_imm_src), 32'h0);
    chk("lw_reg_write", 32'(id_reg_write), 32'h1);
    chk("lw_alu_src", 32'(id_alu_src), 32'h1);
    chk("lw_result_src", 32'(id_result_src), 32'h1);
    cycles(2);

    // 3: back-to-back A,B,C with downstream stalled, then drain
    id_ready = 1'b0;
    pop_log.delete();
    send(32'h200, 32'h002081B3);
    send(32'h204, 32'h00108093);
    to_neg();
    chk("full_if_ready", 32'(if_ready), 32'h0);
    chk("full_holds_a", id_pc, 32'h200);
    cycles(1);
    fork
      send(32'h208, 32'h000080E7);
      begin cycles(3); id_ready = 1'b1; end
    join
    cycles(4);
    chk("drain_count", 32'(pop_log.size()), 32'd3);
    if (pop_log.size() == 3) begin
      chk("drain_a", pop_log[0], 32'h200);
      chk("drain_b", pop_log[1], 32'h204);
      chk("drain_c", pop_log[2], 32'h208);
    end

    // 4: flush while FULL with an incoming offer
    id_ready = 1'b0;
    send(32'h300, 32'h00000097);
    send(32'h304, 32'h123450B7);
    flush = 1'b1; if_valid = 1'b1; if_pc = 32'h308; if_instr = 32'h00112223;
    cycles(1);
    flush = 1'b0; if_valid = 1'b0;
    to_neg();
    chk("flush_id_valid", 32'(id_valid), 32'h0);
    chk("flush_if_ready", 32'(if_ready), 32'h1);
    chk("flush_id_instr", id_instr, 32'h00000013);
    cycles(1);

    // 5: decode sweep
    id_ready = 1'b1;
    send(32'h400, 32'h00112223);
    to_neg();
    chk("sw_imm_src", 32'(id_imm_src), 32'h1);
    chk("sw_mem_write", 32'(id_mem_write), 32'h1);
    chk("sw_reg_write", 32'(id_reg_write), 32'h0);
    cycles(1);
    send(32'h404, 32'h00208463);
    to_neg();
    chk("beq_imm_src", 32'(id_imm_src), 32'h2);
    chk("beq_branch", 32'(id_branch), 32'h1);
    chk("beq_alu_op", 32'(id_alu_op), 32'h1);
    cycles(1);
    send(32'h408, 32'h008000EF);
    to_neg();
    chk("jal_imm_src", 32'(id_imm_src), 32'h3);
    chk("jal_jump", 32'(id_jump), 32'h1);
    chk("jal_result_src", 32'(id_result_src), 32'h2);
    cycles(1);
    send(32'h40C, 32'h123450B7);
    to_neg();
    chk("lui_imm_src", 32'(id_imm_src), 32'h4);
    cycles(1);
    send(32'h410, 32'hFFFFFFFF);
    to_neg();
    chk("ill_valid", 32'(id_valid), 32'h1);
    chk("ill_illegal", 32'(id_illegal), 32'h1);
    chk("ill_enables", 32'({id_reg_write, id_mem_write, id_branch, id_jump, id_alu_src}), 32'h0);
    cycles(1);

    // 6: reset while FULL
    id_ready = 1'b0;
    send(32'h500, 32'h00412083);
    send(32'h504, 32'h00112223);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    to_neg();
    chk("rstfull_id_valid", 32'(id_valid), 32'h0);
    cycles(1);
    id_ready = 1'b1;
    cycles(3);
    to_neg();
    chk("rstfull_no_stale", 32'(id_valid), 32'h0);
    cycles(1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
